// File: rtl/axis_sum_pkg.sv
// ============================================================================
// Module : axis_sum_pkg
// Brief  : Shared types and constants for the complex summing scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_sum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Lane index = 2*channel + imag
    localparam int CH00_RE = 0;
    localparam int CH00_IM = 1;
    localparam int CH01_RE = 2;
    localparam int CH01_IM = 3;
    localparam int CH20_RE = 4;
    localparam int CH20_IM = 5;
    localparam int CH21_RE = 6;
    localparam int CH21_IM = 7;

    localparam int c_DEF_NUM_LANES = 8;
    localparam int c_DEF_FRAME_LEN = 256;
    localparam int c_DEF_CNT_WIDTH = 16;
    localparam int c_DEF_TIMEOUT   = 1024;

endpackage

`default_nettype wire

// File: rtl/axis_sum_watchdog.sv
// ============================================================================
// Module : axis_sum_watchdog
// Brief  : Counts consecutive partial-valid cycles; pulses expire on the
//          TIMEOUT-th one.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sum_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_any_v,
    input  logic i_all_v,
    input  logic i_clr,
    output logic o_expire
);

    localparam int c_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(TIMEOUT - 1);

    logic [c_WIDTH-1:0] r_cnt;
    logic               w_partial;

    assign w_partial = i_any_v & ~i_all_v & ~i_clr;
    assign o_expire  = w_partial & (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_partial || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_sum_sched.sv
// ============================================================================
// Module : axis_sum_sched
// Brief  : Aligns 8 AXIS lanes to a frame boundary and issues joined beats.
//          Optional statistics counters: define AXIS_SUM_SCHED_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sum_sched
    import axis_sum_pkg::*;
#(
    parameter int NUM_LANES = c_DEF_NUM_LANES,
    parameter int FRAME_LEN = c_DEF_FRAME_LEN,
    parameter int CNT_WIDTH = c_DEF_CNT_WIDTH,
    parameter int TIMEOUT   = c_DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_enable,
    input  logic [NUM_LANES-1:0] i_s_tvalid,
    input  logic [NUM_LANES-1:0] i_s_tlast,
    output logic [NUM_LANES-1:0] o_s_tready,
    input  logic                 i_dp_ready,
    output logic                 o_dp_fire,
    output logic                 o_dp_tlast,
    output logic                 o_busy,
    output logic                 o_aligned,
    output logic [CNT_WIDTH-1:0] o_beat_cnt,
    output logic [CNT_WIDTH-1:0] o_frame_cnt,
    output logic                 o_err_misalign,
    output logic                 o_err_timeout,
    input  logic                 i_err_clear
`ifdef AXIS_SUM_SCHED_STATS_EN
   ,output logic [CNT_WIDTH-1:0] o_drop_cnt,
    output logic [CNT_WIDTH-1:0] o_stall_cnt
`endif
);

    localparam logic [CNT_WIDTH-1:0] c_LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);

    state_t                 r_state, w_state_nxt;
    logic [NUM_LANES-1:0]   r_lane_seen, w_lane_seen_nxt;
    logic [CNT_WIDTH-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [CNT_WIDTH-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic                   r_err_mis, w_err_mis_nxt;
    logic                   r_err_to, w_err_to_nxt;
    logic                   r_stop_pend, w_stop_pend_nxt;

    logic                   w_all_v, w_any_v, w_fire, w_last_beat;
    logic                   w_tlast_ok, w_misalign, w_expire;
    logic [NUM_LANES-1:0]   w_tready, w_hs;

    assign w_all_v     = &i_s_tvalid;
    assign w_any_v     = |i_s_tvalid;
    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
    assign w_fire      = (r_state == RUN) & w_all_v & i_dp_ready & ~rst;
    assign w_tlast_ok  = w_last_beat ? (&i_s_tlast) : ~(|i_s_tlast);
    assign w_misalign  = w_fire & ~w_tlast_ok;
    assign w_hs        = i_s_tvalid & w_tready;

    always_comb begin
        w_tready = '0;
        if (!rst) begin
            case (r_state)
                ALIGN:   w_tready = ~r_lane_seen;
                RUN:     w_tready = {NUM_LANES{w_fire}};
                default: w_tready = '0;
            endcase
        end
    end

    assign o_s_tready     = w_tready;
    assign o_dp_fire      = w_fire;
    assign o_dp_tlast     = w_fire & w_last_beat;
    assign o_busy         = (r_state != IDLE);
    assign o_aligned      = (r_state == RUN);
    assign o_beat_cnt     = r_beat_cnt;
    assign o_frame_cnt    = r_frame_cnt;
    assign o_err_misalign = r_err_mis;
    assign o_err_timeout  = r_err_to;

    axis_sum_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_any_v  (w_any_v),
        .i_all_v  (w_all_v),
        .i_clr    (r_state != RUN),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_lane_seen_nxt = r_lane_seen;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_stop_pend_nxt = r_stop_pend;
        case (r_state)
            IDLE: begin
                if (i_cfg_enable) begin
                    w_state_nxt     = ALIGN;
                    w_lane_seen_nxt = '0;
                end
            end
            ALIGN: begin
                w_lane_seen_nxt = r_lane_seen | (w_hs & i_s_tlast);
                if (!i_cfg_enable) begin
                    w_state_nxt = IDLE;
                end else if (&w_lane_seen_nxt) begin
                    w_state_nxt     = RUN;
                    w_beat_cnt_nxt  = '0;
                    w_stop_pend_nxt = 1'b0;
                end
            end
            RUN: begin
                w_stop_pend_nxt = ~i_cfg_enable;
                if (w_fire) begin
                    if (w_last_beat) begin
                        w_beat_cnt_nxt  = '0;
                        w_frame_cnt_nxt = r_frame_cnt + CNT_WIDTH'(1);
                    end else begin
                        w_beat_cnt_nxt  = r_beat_cnt + CNT_WIDTH'(1);
                    end
                end
                // The misaligned beat's tlast bits tell which lanes already hit their boundary
                if (w_misalign) begin
                    w_state_nxt     = ALIGN;
                    w_lane_seen_nxt = i_s_tlast;
                end else if (w_expire) begin
                    w_state_nxt     = ALIGN;
                    w_lane_seen_nxt = '0;
                end else if (r_stop_pend &&
                             ((w_fire && w_last_beat) ||
                              (!w_fire && r_beat_cnt == '0))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_err_mis_nxt = w_misalign | (r_err_mis & ~i_err_clear);
    assign w_err_to_nxt  = w_expire   | (r_err_to  & ~i_err_clear);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lane_seen <= '0;
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
            r_err_mis   <= 1'b0;
            r_err_to    <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane_seen <= w_lane_seen_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err_mis   <= w_err_mis_nxt;
            r_err_to    <= w_err_to_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

`ifdef AXIS_SUM_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] r_drop_cnt, r_stall_cnt;
    logic [CNT_WIDTH:0]   w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_WIDTH+1)'($countones(w_hs));

    always_ff @(posedge clk) begin
        if (rst || i_err_clear) begin
            r_drop_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == ALIGN) begin
                r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
            end
            if (r_state == RUN && w_all_v && !i_dp_ready && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_drop_cnt  = r_drop_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_sum_sched.sv
// ============================================================================
// Module : tb_axis_sum_sched
// Brief  : Directed self-checking bench for axis_sum_sched (FRAME_LEN=4,
//          TIMEOUT=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_sum_sched;
    import axis_sum_pkg::*;

    localparam int NL = 8;
    localparam int FL = 4;
    localparam int CW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [NL-1:0] s_tvalid, s_tlast, s_tready;
    logic          dp_ready, dp_fire, dp_tlast;
    logic          busy, aligned, err_misalign, err_timeout, err_clear;
    logic [CW-1:0] beat_cnt, frame_cnt;
`ifdef AXIS_SUM_SCHED_STATS_EN
    logic [CW-1:0] drop_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    axis_sum_sched #(
        .NUM_LANES (NL),
        .FRAME_LEN (FL),
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cfg_enable   (cfg_enable),
        .i_s_tvalid     (s_tvalid),
        .i_s_tlast      (s_tlast),
        .o_s_tready     (s_tready),
        .i_dp_ready     (dp_ready),
        .o_dp_fire      (dp_fire),
        .o_dp_tlast     (dp_tlast),
        .o_busy         (busy),
        .o_aligned      (aligned),
        .o_beat_cnt     (beat_cnt),
        .o_frame_cnt    (frame_cnt),
        .o_err_misalign (err_misalign),
        .o_err_timeout  (err_timeout),
        .i_err_clear    (err_clear)
`ifdef AXIS_SUM_SCHED_STATS_EN
       ,.o_drop_cnt     (drop_cnt),
        .o_stall_cnt    (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NL-1:0] v, input logic [NL-1:0] l, input logic rdy);
        s_tvalid = v;
        s_tlast  = l;
        dp_ready = rdy;
        #1;
    endtask

    int nb[NL] = '{3, 5, 0, 7, 1, 2, 4, 6};
    int sent[NL];
    int n_cyc;
    int b;
    logic [3:0] rdy_seq;

    initial begin
        rst = 1'b1; cfg_enable = 1'b0; err_clear = 1'b0;
        s_tvalid = '0; s_tlast = '0; dp_ready = 1'b0;
        tick; tick;

        // Reset state, including no transfers while reset is high
        drive('1, '0, 1'b1);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_tready", s_tready, 0);
        chk_eq("rst_fire", dp_fire, 0);
        chk_eq("rst_beat", beat_cnt, 0);
        chk_eq("rst_frame", frame_cnt, 0);
        chk_eq("rst_errs", {err_misalign, err_timeout}, 0);
        rst = 1'b0;

        // Align: each lane drains its own pre-boundary beats plus the tlast beat
        cfg_enable = 1'b1;
        for (int k = 0; k < NL; k++) sent[k] = 0;
        n_cyc = 0;
        while (!aligned && n_cyc < 30) begin
            for (int k = 0; k < NL; k++) s_tlast[k] = (sent[k] == nb[k]);
            s_tvalid = '1;
            dp_ready = 1'b1;
            #1;
            chk_eq("align_nofire", dp_fire, 0);
            for (int k = 0; k < NL; k++) if (s_tready[k]) sent[k]++;
            tick;
            n_cyc++;
        end
        chk_eq("align_cycles", n_cyc, 9);
        for (int k = 0; k < NL; k++) chk_eq($sformatf("align_drop_lane%0d", k), sent[k], nb[k] + 1);
        chk_eq("align_beat0", beat_cnt, 0);
`ifdef AXIS_SUM_SCHED_STATS_EN
        chk_eq("align_drop_cnt", drop_cnt, 36);
`endif

        // Steady frame
        for (int i = 0; i < FL; i++) begin
            drive('1, (i == FL-1) ? '1 : '0, 1'b1);
            chk_eq($sformatf("steady_fire%0d", i), dp_fire, 1);
            chk_eq($sformatf("steady_tlast%0d", i), dp_tlast, (i == FL-1));
            chk_eq($sformatf("steady_tready%0d", i), s_tready, 8'hFF);
            tick;
        end
        chk_eq("steady_frame", frame_cnt, 1);
        chk_eq("steady_beat", beat_cnt, 0);

        // Backpressure 1010
        rdy_seq = 4'b0101;
        b = 0;
        for (int i = 0; i < 4; i++) begin
            drive('1, (b == FL-1) ? '1 : '0, rdy_seq[i]);
            chk_eq($sformatf("bp_tready%0d", i), s_tready, rdy_seq[i] ? 8'hFF : 8'h00);
            if (rdy_seq[i]) b++;
            tick;
        end
        chk_eq("bp_beat", beat_cnt, 2);
        chk_eq("bp_no_timeout", err_timeout, 0);
`ifdef AXIS_SUM_SCHED_STATS_EN
        chk_eq("bp_stall_cnt", stall_cnt, 2);
`endif
        for (int i = 2; i < FL; i++) begin
            drive('1, (i == FL-1) ? '1 : '0, 1'b1);
            tick;
        end
        chk_eq("bp_frame", frame_cnt, 2);

        // Misalign: one lane asserts tlast at beat 1
        drive('1, '0, 1'b1);
        tick;
        drive('1, 8'(1 << CH01_IM), 1'b1);
        chk_eq("mis_fire", dp_fire, 1);
        tick;
        chk_eq("mis_err", err_misalign, 1);
        chk_eq("mis_state", {busy, aligned}, 2'b10);
        drive('0, '0, 1'b1);
        chk_eq("mis_seen", s_tready, 8'hF7);
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        chk_eq("mis_clear", err_misalign, 0);
        drive('1, '1, 1'b1);
        tick;
        chk_eq("mis_realign", aligned, 1);

        // Starvation: lane 5 never valid; err_clear on the expiry cycle loses
        for (int i = 1; i <= TO; i++) begin
            err_clear = (i == TO);
            drive(~8'(1 << CH20_IM), '0, 1'b1);
            chk_eq($sformatf("starve_nofire%0d", i), dp_fire, 0);
            tick;
            chk_eq($sformatf("starve_err%0d", i), err_timeout, (i == TO));
            chk_eq($sformatf("starve_run%0d", i), aligned, (i < TO));
        end
        err_clear = 1'b0;
        chk_eq("starve_busy", busy, 1);
        err_clear = 1'b1;
        drive('1, '1, 1'b1);
        tick;
        err_clear = 1'b0;
        chk_eq("starve_clear", err_timeout, 0);
        chk_eq("starve_realign", aligned, 1);

        // Stop at beat 1: the frame completes, then IDLE
        for (int i = 0; i < FL; i++) begin
            cfg_enable = (i == 0);
            drive('1, (i == FL-1) ? '1 : '0, 1'b1);
            chk_eq($sformatf("stop_fire%0d", i), dp_fire, 1);
            tick;
        end
        chk_eq("stop_idle", busy, 0);
        chk_eq("stop_frame", frame_cnt, 3);
        drive('1, '0, 1'b1);
        chk_eq("stop_tready", s_tready, 0);

        // Reset mid-frame
        cfg_enable = 1'b1;
        drive('0, '0, 1'b1);
        tick;
        drive('1, '1, 1'b1);
        tick;
        drive('1, '0, 1'b1);
        tick;
        drive('1, '0, 1'b1);
        tick;
        chk_eq("mid_beat", beat_cnt, 2);
        rst = 1'b1;
        drive('1, '0, 1'b1);
        chk_eq("mid_rst_tready", s_tready, 0);
        chk_eq("mid_rst_fire", dp_fire, 0);
        tick;
        chk_eq("mid_rst_busy", busy, 0);
        chk_eq("mid_rst_beat", beat_cnt, 0);
        chk_eq("mid_rst_frame", frame_cnt, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
